// File: rtl/alu_muldiv_seq_if.sv
// Command/result bundle between the datapath controller and the multiply/divide sequencer.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned 8x8 multiply / 8/8 divide sequencer, one pass of the shared ALU per clock.
//   state  | meaning
//   S_IDLE | waiting for start, ALU released
//   S_RUN  | one shift-add / restoring-subtract step per cycle, cnt 0..ITER-1
//   S_DONE | one-cycle done pulse, results held afterwards
module alu_muldiv_seq #(
  parameter int WIDTH = 8,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_seq_if.slave  cmd,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_acode,
  output logic [1:0]       alu_scode,
  output logic             alu_is_shift,
  output logic             alu_carry_in,
  output logic             alu_update_z_c,
  input  logic [WIDTH-1:0] alu_R,
  input  logic             alu_carry_out
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int            CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [2:0]    AC_ADD   = 3'b000;
  localparam logic [2:0]    AC_SUB   = 3'b010;

  state_t           state, state_nxt;
  logic             op_q;
  logic [WIDTH-1:0] acc, lo, m;
  logic [WIDTH-1:0] acc_nxt, lo_nxt, s_div;
  logic             q_bit;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             dbz;
  logic             div_zero_req;

  assign div_zero_req = cmd.op && (cmd.opb == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd.start) state_nxt = div_zero_req ? S_DONE : S_RUN;
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU drive and per-step datapath update; only registered state feeds the ALU operands.
  always_comb begin
    alu_A          = '0;
    alu_B          = '0;
    alu_acode      = AC_ADD;
    alu_update_z_c = 1'b0;
    s_div          = {acc[WIDTH-2:0], lo[WIDTH-1]};
    q_bit          = 1'b0;
    acc_nxt        = acc;
    lo_nxt         = lo;
    if (state == S_RUN) begin
      alu_update_z_c = 1'b1;
      if (op_q) begin
        alu_A     = s_div;
        alu_B     = m;
        alu_acode = AC_SUB;
        // acc[MSB] set means the shifted remainder exceeds WIDTH bits, so it always covers m
        q_bit     = acc[WIDTH-1] | alu_carry_out;
        acc_nxt   = q_bit ? alu_R : s_div;
        lo_nxt    = {lo[WIDTH-2:0], q_bit};
      end else begin
        alu_A   = acc;
        alu_B   = lo[0] ? m : '0;
        acc_nxt = {alu_carry_out, alu_R[WIDTH-1:1]};
        lo_nxt  = {alu_R[0], lo[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      m      <= '0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.start) begin
            op_q <= cmd.op;
            lo   <= cmd.opa;
            m    <= cmd.opb;
            acc  <= '0;
            cnt  <= '0;
            if (div_zero_req) begin
              res_hi <= cmd.opa;
              res_lo <= '1;
              dbz    <= 1'b1;
            end else begin
              res_hi <= '0;
              res_lo <= '0;
              dbz    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            res_hi <= acc_nxt;
            res_lo <= lo_nxt;
            dbz    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.busy        = (state != S_IDLE);
  assign cmd.done        = (state == S_DONE);
  assign cmd.result_hi   = res_hi;
  assign cmd.result_lo   = res_lo;
  assign cmd.div_by_zero = dbz;

  assign alu_scode    = 2'b00;
  assign alu_is_shift = 1'b0;
  assign alu_carry_in = 1'b0;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: sequencer driving a behavioural 8-bit ALU, checked against plain arithmetic.
module tb_alu_muldiv_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_A, alu_B, alu_R;
  logic [2:0] alu_acode;
  logic [1:0] alu_scode;
  logic       alu_is_shift, alu_carry_in, alu_update_z_c, alu_carry_out;
  logic [8:0] alu_sum;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv_seq_if #(.WIDTH(8)) cif ();

  alu_muldiv_seq #(.WIDTH(8), .ITER(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cif),
    .alu_A          (alu_A),
    .alu_B          (alu_B),
    .alu_acode      (alu_acode),
    .alu_scode      (alu_scode),
    .alu_is_shift   (alu_is_shift),
    .alu_carry_in   (alu_carry_in),
    .alu_update_z_c (alu_update_z_c),
    .alu_R          (alu_R),
    .alu_carry_out  (alu_carry_out)
  );

  always #5 clk = ~clk;

  // ALU: ADD carries out on overflow, SUB carries out when there is no borrow.
  always_comb begin
    alu_sum       = 9'd0;
    alu_carry_out = 1'b0;
    if (alu_acode == 3'b010) begin
      alu_sum       = {1'b0, alu_A} - {1'b0, alu_B};
      alu_carry_out = ~alu_sum[8];
    end else if (alu_acode == 3'b000) begin
      alu_sum       = {1'b0, alu_A} + {1'b0, alu_B} + {8'd0, alu_carry_in};
      alu_carry_out = alu_sum[8];
    end
    alu_R = alu_sum[7:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic ref_calc(input logic o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] hi, output logic [7:0] lo, output logic dz);
    int p;
    dz = 1'b0;
    if (!o) begin
      p  = int'(a) * int'(b);
      hi = 8'(p >> 8);
      lo = 8'(p);
    end else if (b == 8'd0) begin
      hi = a;
      lo = 8'hFF;
      dz = 1'b1;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  // Starts an op at the next edge; inj>0 pulses a stray start in that RUN cycle.
  task automatic do_op(input string name, input logic o, input logic [7:0] a, input logic [7:0] b,
                       input int inj);
    logic [7:0] ehi, elo;
    logic       edz;
    int         cyc, exp_lat;
    bit         seen_uz, busy_low;
    ref_calc(o, a, b, ehi, elo, edz);
    exp_lat   = edz ? 1 : 9;
    cif.start = 1'b1;
    cif.op    = o;
    cif.opa   = a;
    cif.opb   = b;
    @(posedge clk); #1;
    cif.start = 1'b0;
    cif.opa   = 8'($urandom);
    cif.opb   = 8'($urandom);
    cyc       = 1;
    seen_uz   = 1'b0;
    busy_low  = 1'b0;
    forever begin
      if (cyc == inj) begin
        cif.start = 1'b1;
        cif.op    = ~o;
        cif.opa   = ~a;
        cif.opb   = b + 8'd1;
      end
      @(negedge clk);
      if (alu_update_z_c) seen_uz = 1'b1;
      if (!cif.busy) busy_low = 1'b1;
      if (cif.done || cyc >= 20) break;
      @(posedge clk); #1;
      cif.start = 1'b0;
      cyc++;
    end
    check_eq({name, " latency"}, cyc, exp_lat);
    check_eq({name, " hi"}, cif.result_hi, ehi);
    check_eq({name, " lo"}, cif.result_lo, elo);
    check_eq({name, " dbz"}, cif.div_by_zero, edz);
    check_eq({name, " busy_gap"}, busy_low, 0);
    check_eq({name, " upd_zc"}, seen_uz, edz ? 0 : 1);
    @(posedge clk);
    @(negedge clk);
    check_eq({name, " done_1cyc"}, cif.done, 0);
    check_eq({name, " idle_busy"}, cif.busy, 0);
    check_eq({name, " hold"}, {cif.div_by_zero, cif.result_hi, cif.result_lo}, {edz, ehi, elo});
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, " busy/done"}, {cif.busy, cif.done}, 0);
    check_eq({name, " results"}, {cif.div_by_zero, cif.result_hi, cif.result_lo}, 0);
    check_eq({name, " alu_ops"}, {alu_A, alu_B, alu_acode, alu_update_z_c}, 0);
    check_eq({name, " alu_ties"}, {alu_scode, alu_is_shift, alu_carry_in}, 0);
  endtask

  initial begin
    bit done_seen;
    rst       = 1'b1;
    cif.start = 1'b0;
    cif.op    = 1'b0;
    cif.opa   = 8'd0;
    cif.opb   = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    do_op("mul_13x11", 1'b0, 8'd13, 8'd11, 0);
    do_op("mul_ffxff", 1'b0, 8'hFF, 8'hFF, 0);
    do_op("mul_0xa5", 1'b0, 8'h00, 8'hA5, 0);
    do_op("div_200_7", 1'b1, 8'd200, 8'd7, 0);
    do_op("div_ff_80", 1'b1, 8'hFF, 8'h80, 0);
    do_op("div_ff_01", 1'b1, 8'hFF, 8'h01, 0);
    do_op("div_5a_0", 1'b1, 8'h5A, 8'h00, 0);
    do_op("ign_start", 1'b0, 8'd13, 8'd11, 3);
    do_op("b2b", 1'b1, 8'd200, 8'd7, 0);

    cif.start = 1'b1;
    cif.op    = 1'b0;
    cif.opa   = 8'hC8;
    cif.opb   = 8'h33;
    @(posedge clk); #1;
    cif.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_run");
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (cif.done || cif.busy) done_seen = 1'b1;
    end
    check_eq("rst_no_done", done_seen, 0);
    do_op("mul_3x5", 1'b0, 8'd3, 8'd5, 0);

    for (int i = 0; i < 40; i++) begin
      logic       o;
      logic [7:0] a, b;
      o = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      do_op($sformatf("rand%0d", i), o, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
